// File: rtl/mkd_pkg.sv
// ---------------------------------------------------------------------------
// mkd_pkg: shared helpers, default widths and key-state type for multi_key_debouncer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mkd_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << w) < value) begin
                w = w + 1;
            end
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    localparam int C_TICK_DIV_DEF     = 2048;
    localparam int C_STABLE_CNT_DEF   = 4;
    localparam int C_HOLD_TICKS_DEF   = 255;
    localparam int C_REPEAT_TICKS_DEF = 64;

    localparam int C_PRESCALE_W = clog2(C_TICK_DIV_DEF);
    localparam int C_STABLE_W   = clog2(C_STABLE_CNT_DEF + 1);
    localparam int C_HOLD_W     = clog2(C_HOLD_TICKS_DEF + 1);
    localparam int C_REPEAT_W   = clog2(C_REPEAT_TICKS_DEF + 1);

    typedef struct packed {
        logic                  level;
        logic [C_STABLE_W-1:0] stable_cnt;
        logic [C_HOLD_W-1:0]   hold_cnt;
    } key_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ---------------------------------------------------------------------------
// key_debounce_channel: one key's synchroniser, stable-count filter, edges and hold window
// Optional auto-repeat when AUTO_REPEAT_EN is defined.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce_channel
    import mkd_pkg::*;
#(
    parameter int STABLE_CNT   = C_STABLE_CNT_DEF,
    parameter int HOLD_TICKS   = C_HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = C_REPEAT_TICKS_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic TICK,
    input  logic KEY_N,
    output logic KEY_LEVEL,
    output logic KEY_PRESS,
    output logic KEY_RELEASE,
    output logic KEY_HOLD
);

    localparam int C_SW = clog2(STABLE_CNT + 1);
    localparam int C_HW = clog2(HOLD_TICKS + 1);
    localparam logic [C_SW-1:0] C_STABLE_LAST = C_SW'(STABLE_CNT - 1);
    localparam logic [C_HW-1:0] C_HOLD_LOAD   = C_HW'(HOLD_TICKS);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [C_SW-1:0] r_stable_cnt;
    logic [C_HW-1:0] r_hold_cnt;
    logic            r_press;
    logic            r_release;

    logic w_sample;
    logic w_differs;
    logic w_toggle;
    logic w_rise;
    logic w_fall;
    logic w_press_evt;

    assign w_sample  = ~r_sync2;
    assign w_differs = (w_sample != r_level);
    // The count-reaching-STABLE_CNT step toggles instead of storing, so the counter never exceeds STABLE_CNT-1.
    assign w_toggle  = TICK && w_differs && (r_stable_cnt >= C_STABLE_LAST);
    assign w_rise    = w_toggle && !r_level;
    assign w_fall    = w_toggle && r_level;

`ifdef AUTO_REPEAT_EN
    localparam int C_RW = clog2(REPEAT_TICKS + 1);
    localparam logic [C_RW-1:0] C_REPEAT_LAST = C_RW'(REPEAT_TICKS - 1);

    logic [C_RW-1:0] r_repeat_cnt;
    logic            w_repeat;

    assign w_repeat    = TICK && r_level && !w_fall && (r_repeat_cnt == C_REPEAT_LAST);
    assign w_press_evt = w_rise || w_repeat;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_repeat_cnt <= '0;
        end else if (!r_level || w_fall || w_repeat) begin
            r_repeat_cnt <= '0;
        end else if (TICK) begin
            r_repeat_cnt <= r_repeat_cnt + 1'b1;
        end
    end
`else
    assign w_press_evt = w_rise;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_level      <= 1'b0;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
        end else begin
            r_sync1   <= KEY_N;
            r_sync2   <= r_sync1;
            r_press   <= w_press_evt;
            r_release <= w_fall;

            if (TICK) begin
                if (!w_differs || w_toggle) begin
                    r_stable_cnt <= '0;
                end else begin
                    r_stable_cnt <= r_stable_cnt + 1'b1;
                end
                if (w_toggle) begin
                    r_level <= ~r_level;
                end
            end

            if (w_press_evt) begin
                r_hold_cnt <= C_HOLD_LOAD;
            end else if (TICK && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    assign KEY_LEVEL   = r_level;
    assign KEY_PRESS   = r_press;
    assign KEY_RELEASE = r_release;
    assign KEY_HOLD    = (r_hold_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/multi_key_debouncer.sv
// ---------------------------------------------------------------------------
// multi_key_debouncer: shared sample-tick prescaler feeding N_KEYS debounce channels
// Optional auto-repeat when AUTO_REPEAT_EN is defined.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_key_debouncer
    import mkd_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = C_TICK_DIV_DEF,
    parameter int STABLE_CNT   = C_STABLE_CNT_DEF,
    parameter int HOLD_TICKS   = C_HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = C_REPEAT_TICKS_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY_N,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_HOLD,
    output logic              TICK
);

    localparam int C_PW = clog2(TICK_DIV);
    localparam logic [C_PW-1:0] C_PRESCALE_LAST = C_PW'(TICK_DIV - 1);

    logic [C_PW-1:0] r_prescale;
    logic            w_tick;

    assign w_tick = (r_prescale == C_PRESCALE_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    assign TICK = w_tick;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_channel #(
            .STABLE_CNT   (STABLE_CNT),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_channel (
            .CLK         (CLK),
            .RESET       (RESET),
            .TICK        (w_tick),
            .KEY_N       (KEY_N[g]),
            .KEY_LEVEL   (KEY_LEVEL[g]),
            .KEY_PRESS   (KEY_PRESS[g]),
            .KEY_RELEASE (KEY_RELEASE[g]),
            .KEY_HOLD    (KEY_HOLD[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_key_debouncer: directed vector table plus hand-written reset and glitch sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multi_key_debouncer;

    logic       CLK;
    logic       RESET;
    logic [3:0] KEY_N;
    logic [3:0] KEY_LEVEL;
    logic [3:0] KEY_PRESS;
    logic [3:0] KEY_RELEASE;
    logic [3:0] KEY_HOLD;
    logic       TICK;

    int n_vec;
    int n_fail;

    multi_key_debouncer #(
        .N_KEYS       (4),
        .TICK_DIV     (4),
        .STABLE_CNT   (3),
        .HOLD_TICKS   (5),
        .REPEAT_TICKS (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .KEY_N       (KEY_N),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE),
        .KEY_HOLD    (KEY_HOLD),
        .TICK        (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] key_n;
        int         cycles;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] hold;
        logic       tick;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance n cycles, sampling at each falling edge; press/release overlap is checked every cycle.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("press_release_overlap", 32'(KEY_PRESS & KEY_RELEASE), 32'd0);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] lv, input logic [3:0] pr,
                           input logic [3:0] rl, input logic [3:0] hd, input logic tk);
        chk({name, " level"},   32'(KEY_LEVEL),   32'(lv));
        chk({name, " press"},   32'(KEY_PRESS),   32'(pr));
        chk({name, " release"}, 32'(KEY_RELEASE), 32'(rl));
        chk({name, " hold"},    32'(KEY_HOLD),    32'(hd));
        chk({name, " tick"},    32'(TICK),        32'(tk));
    endtask

    vec_t vecs [14];

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Cycle index k below = number of rising edges since RESET released; sampled on the falling edge after edge k.
        vecs[0]  = '{4'b1111,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // k=2
        vecs[1]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1}; // k=3 first tick
        vecs[2]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // k=4
        vecs[3]  = '{4'b1110, 11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1}; // k=15 key0 not yet stable
        vecs[4]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0}; // k=16 press
        vecs[5]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0}; // k=17 pulse gone
        vecs[6]  = '{4'b1110, 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1}; // k=35 last hold cycle
        vecs[7]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // k=36 hold expired
        vecs[8]  = '{4'b1111, 11, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1}; // k=47
        vecs[9]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0}; // k=48 release
        vecs[10] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // k=49
        vecs[11] = '{4'b0011, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1}; // k=59
        vecs[12] = '{4'b0011,  1, 4'b1100, 4'b1100, 4'b0000, 4'b1100, 1'b0}; // k=60 dual press
        vecs[13] = '{4'b0011,  1, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 1'b0}; // k=61

        // Reset held with all keys pressed: outputs stay cleared.
        RESET = 1'b0;
        KEY_N = 4'b0000;
        step(10);
        chk_all("in_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        KEY_N = 4'b1111;
        RESET = 1'b1;

        for (int i = 0; i < 14; i++) begin
            KEY_N = vecs[i].key_n;
            step(vecs[i].cycles);
            chk_all($sformatf("vec%0d", i), vecs[i].level, vecs[i].press,
                    vecs[i].rel, vecs[i].hold, vecs[i].tick);
        end

        // Key0 pressed again alongside keys 2/3, then reset lands mid-hold.
        KEY_N = 4'b0010;
        step(11);
        chk_all("repress k72", 4'b1101, 4'b0001, 4'b0000, 4'b1101, 1'b0);
        step(5);
        chk("hold0 mid-window", 32'(KEY_HOLD[0]), 32'd1);

        @(posedge CLK);
        #2 RESET = 1'b0;
        #1 chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step(11);
        chk_all("after_reset k11", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        step(1);
        chk_all("after_reset k12", 4'b1101, 4'b1101, 4'b0000, 4'b1101, 1'b0);
        step(1);
        chk("after_reset k13 press", 32'(KEY_PRESS), 32'd0);

        // Key1 bouncing with a 6-cycle period never yields three equal samples in a row.
        for (int c = 0; c < 60; c++) begin
            KEY_N = {2'b00, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b0};
            step(1);
            chk($sformatf("glitch c%0d key1", c),
                32'({KEY_LEVEL[1], KEY_PRESS[1], KEY_RELEASE[1]}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
